// File: rtl/bisg_sig_checker.sv
// -----------------------------------------------------------------------------
// bisg_sig_checker
//
// Response-side companion to the BISG scan source. Watches the asynchronous
// serial scan stream, compacts every captured bit into a serial-input
// signature register (Galois LFSR), counts the captured bits and, at end of
// scan, compares signature and count against golden values.
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse arming a new check
//   TCK        in   scan clock (sampled as data, asynchronous)
//   test_se    in   scan enable (asynchronous)
//   digi_out   in   scan data bit (asynchronous)
//   scan_done  in   end-of-scan level (asynchronous)
//   ScanNum    in   expected number of shifted bits
//   golden     in   expected signature
//   sig        out  current signature
//   bit_cnt    out  number of bits captured
//   pass       out  result, meaningful only while pass_valid is 1
//   pass_valid out  a result is available
//   cnt_err    out  bit count differed from ScanNum (or overflowed) at check
//   ovf        out  bit count saturated
// -----------------------------------------------------------------------------
module bisg_sig_checker #(
    parameter int                   sigLength = 13,
    parameter logic [sigLength-1:0] POLY      = 13'h001B,
    parameter logic [sigLength-1:0] SEED      = {sigLength{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 TCK,
    input  logic                 test_se,
    input  logic                 digi_out,
    input  logic                 scan_done,
    input  logic [19:0]          ScanNum,
    input  logic [sigLength-1:0] golden,
    output logic [sigLength-1:0] sig,
    output logic [19:0]          bit_cnt,
    output logic                 pass,
    output logic                 pass_valid,
    output logic                 cnt_err,
    output logic                 ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [19:0] CNT_MAX = 20'hFFFFF;

    // One compaction step: shift left, fold in the feedback taps when the
    // outgoing MSB differs from the incoming data bit.
    function automatic logic [sigLength-1:0] sig_step(
        input logic [sigLength-1:0] cur,
        input logic                 din
    );
        logic fb;
        fb       = cur[sigLength-1] ^ din;
        sig_step = {cur[sigLength-2:0], 1'b0} ^ (fb ? POLY : {sigLength{1'b0}});
    endfunction

    // Synchronizer chains; bit 0 is the first flop. TCK and scan_done carry
    // a third flop for edge detection.
    logic [2:0] tck_sync_r;
    logic [2:0] done_sync_r;
    logic [1:0] se_sync_r;
    logic [1:0] din_sync_r;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [sigLength-1:0]   sig_r;
    logic [19:0]            bit_cnt_r;
    logic                   pass_r;
    logic                   pass_valid_r;
    logic                   cnt_err_r;
    logic                   ovf_r;

    logic tck_rise_s;
    logic done_rise_s;
    logic test_se_s;
    logic din_s;
    logic capture_s;

    assign tck_rise_s  = tck_sync_r[1] & ~tck_sync_r[2];
    assign done_rise_s = done_sync_r[1] & ~done_sync_r[2];
    assign test_se_s   = se_sync_r[1];
    assign din_s       = din_sync_r[1];
    // start wins over a capture in the same cycle.
    assign capture_s   = tck_rise_s & test_se_s & (state_r == SHIFT) & ~start;

    // Synchronize all scan-side inputs into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_sync_r  <= 3'b000;
            done_sync_r <= 3'b000;
            se_sync_r   <= 2'b00;
            din_sync_r  <= 2'b00;
        end else begin
            tck_sync_r  <= {tck_sync_r[1:0], TCK};
            done_sync_r <= {done_sync_r[1:0], scan_done};
            se_sync_r   <= {se_sync_r[0], test_se};
            din_sync_r  <= {din_sync_r[0], digi_out};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; start re-arms from any state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                next_state_s = IDLE;
            end
            SHIFT: begin
                if (done_rise_s) begin
                    next_state_s = CHECK;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            CHECK: begin
                next_state_s = DONE;
            end
            DONE: begin
                next_state_s = DONE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        if (start) begin
            next_state_s = SHIFT;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // Signature, bit counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_r        <= SEED;
            bit_cnt_r    <= 20'd0;
            pass_r       <= 1'b0;
            pass_valid_r <= 1'b0;
            cnt_err_r    <= 1'b0;
            ovf_r        <= 1'b0;
        end else if (start) begin
            sig_r        <= SEED;
            bit_cnt_r    <= 20'd0;
            pass_r       <= 1'b0;
            pass_valid_r <= 1'b0;
            cnt_err_r    <= 1'b0;
            ovf_r        <= 1'b0;
        end else begin
            if (capture_s) begin
                sig_r <= sig_step(sig_r, din_s);
                // A capture with the counter already at its ceiling means a
                // bit went uncounted; flag it and hold the count.
                if (bit_cnt_r == CNT_MAX) begin
                    ovf_r <= 1'b1;
                end else begin
                    bit_cnt_r <= bit_cnt_r + 20'd1;
                end
            end
            if (state_r == CHECK) begin
                cnt_err_r    <= (bit_cnt_r != ScanNum) | ovf_r;
                pass_r       <= (sig_r == golden) & (bit_cnt_r == ScanNum) & ~ovf_r;
                pass_valid_r <= 1'b1;
            end
        end
    end

    assign sig        = sig_r;
    assign bit_cnt    = bit_cnt_r;
    assign pass       = pass_r;
    assign pass_valid = pass_valid_r;
    assign cnt_err    = cnt_err_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_bisg_sig_checker.sv
// -----------------------------------------------------------------------------
// tb_bisg_sig_checker
//
// Table-driven bench for bisg_sig_checker: each record gives a scan pattern
// plus hand-computed signature, count and verdict. Hand-written sequences
// cover restart, asynchronous reset, DONE hold and simultaneous capture/done.
// Inputs are driven on the falling clock edge and outputs sampled there too.
// -----------------------------------------------------------------------------
module tb_bisg_sig_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        TCK;
    logic        test_se;
    logic        digi_out;
    logic        scan_done;
    logic [19:0] ScanNum;
    logic [12:0] golden;
    logic [12:0] sig;
    logic [19:0] bit_cnt;
    logic        pass;
    logic        pass_valid;
    logic        cnt_err;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    bisg_sig_checker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .TCK        (TCK),
        .test_se    (test_se),
        .digi_out   (digi_out),
        .scan_done  (scan_done),
        .ScanNum    (ScanNum),
        .golden     (golden),
        .sig        (sig),
        .bit_cnt    (bit_cnt),
        .pass       (pass),
        .pass_valid (pass_valid),
        .cnt_err    (cnt_err),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          n_ign;     // TCK pulses with test_se low before the bits
        int          n_bits;
        logic [15:0] bits;      // bit 0 is scanned first
        logic [19:0] scan_num;
        logic [12:0] gold;
        logic [12:0] exp_sig;
        logic [19:0] exp_cnt;
        logic        exp_pass;
        logic        exp_cnt_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic scan_bit(input logic b, input logic se);
        @(negedge clk);
        digi_out = b;
        test_se  = se;
        repeat (3) @(negedge clk);
        TCK = 1'b1;
        repeat (3) @(negedge clk);
        TCK = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Wait (bounded) for pass_valid; returns clk edges since call.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!pass_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_done();
        @(negedge clk);
        scan_done = 1'b0;
        TCK       = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int lat;
        logic [19:0] cnt_hold;

        vecs[0] = '{"single_one", 0, 1,  16'h0001, 20'd1,  13'h001B, 13'h001B, 20'd1,  1'b1, 1'b0};
        vecs[1] = '{"one_zero",   0, 2,  16'h0001, 20'd2,  13'h0036, 13'h0036, 20'd2,  1'b1, 1'b0};
        vecs[2] = '{"bad_golden", 0, 2,  16'h0001, 20'd2,  13'h0035, 13'h0036, 20'd2,  1'b0, 1'b0};
        vecs[3] = '{"cnt_mism",   0, 3,  16'h0000, 20'd4,  13'h0000, 13'h0000, 20'd3,  1'b0, 1'b1};
        vecs[4] = '{"ignored",    5, 1,  16'h0001, 20'd1,  13'h001B, 13'h001B, 20'd1,  1'b1, 1'b0};
        vecs[5] = '{"three_ones", 0, 3,  16'h0007, 20'd3,  13'h0041, 13'h0041, 20'd3,  1'b1, 1'b0};
        vecs[6] = '{"msb_fb",     0, 10, 16'h0001, 20'd10, 13'h161B, 13'h161B, 20'd10, 1'b1, 1'b0};

        rst_n     = 1'b0;
        start     = 1'b0;
        TCK       = 1'b0;
        test_se   = 1'b0;
        digi_out  = 1'b0;
        scan_done = 1'b0;
        ScanNum   = 20'd0;
        golden    = 13'h0000;
        repeat (3) @(negedge clk);
        chk("rst_sig", {19'd0, sig}, 32'h0);
        chk("rst_cnt", {12'd0, bit_cnt}, 32'h0);
        chk("rst_flags", {28'd0, pass, pass_valid, cnt_err, ovf}, 32'h0);
        rst_n = 1'b1;

        // IDLE: no capture before any start.
        scan_bit(1'b1, 1'b1);
        chk("idle_nocap", {12'd0, bit_cnt}, 32'h0);

        for (int i = 0; i < 7; i++) begin
            ScanNum = vecs[i].scan_num;
            golden  = vecs[i].gold;
            pulse_start();
            chk({vecs[i].name, "_armed"}, {31'd0, pass_valid}, 32'h0);
            for (int j = 0; j < vecs[i].n_ign; j++) scan_bit(1'b1, 1'b0);
            for (int j = 0; j < vecs[i].n_bits; j++) scan_bit(vecs[i].bits[j], 1'b1);
            @(negedge clk);
            scan_done = 1'b1;
            wait_valid(lat);
            chk({vecs[i].name, "_lat"}, lat, 32'd4);
            chk({vecs[i].name, "_sig"}, {19'd0, sig}, {19'd0, vecs[i].exp_sig});
            chk({vecs[i].name, "_cnt"}, {12'd0, bit_cnt}, {12'd0, vecs[i].exp_cnt});
            chk({vecs[i].name, "_pass"}, {31'd0, pass}, {31'd0, vecs[i].exp_pass});
            chk({vecs[i].name, "_cnt_err"}, {31'd0, cnt_err}, {31'd0, vecs[i].exp_cnt_err});
            chk({vecs[i].name, "_ovf"}, {31'd0, ovf}, 32'h0);
            finish_done();
        end

        // DONE holds its result: further TCK edges are not captured.
        cnt_hold = bit_cnt;
        scan_bit(1'b1, 1'b1);
        chk("done_hold_cnt", {12'd0, bit_cnt}, {12'd0, cnt_hold});
        chk("done_hold_sig", {19'd0, sig}, 32'h161B);
        chk("done_hold_valid", {31'd0, pass_valid}, 32'h1);

        // Restart mid-scan.
        ScanNum = 20'd1;
        golden  = 13'h001B;
        pulse_start();
        scan_bit(1'b1, 1'b1);
        scan_bit(1'b1, 1'b1);
        scan_bit(1'b0, 1'b1);
        chk("restart_pre_cnt", {12'd0, bit_cnt}, 32'd3);
        pulse_start();
        chk("restart_clr_cnt", {12'd0, bit_cnt}, 32'd0);
        chk("restart_clr_sig", {19'd0, sig}, 32'h0);
        scan_bit(1'b1, 1'b1);
        @(negedge clk);
        scan_done = 1'b1;
        wait_valid(lat);
        chk("restart_lat", lat, 32'd4);
        chk("restart_pass", {31'd0, pass}, 32'h1);
        chk("restart_cnt", {12'd0, bit_cnt}, 32'd1);
        finish_done();

        // Asynchronous reset mid-scan clears outputs within the cycle.
        ScanNum = 20'd5;
        pulse_start();
        scan_bit(1'b1, 1'b1);
        scan_bit(1'b0, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sig", {19'd0, sig}, 32'h0);
        chk("arst_cnt", {12'd0, bit_cnt}, 32'h0);
        chk("arst_flags", {28'd0, pass, pass_valid, cnt_err, ovf}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        // A scan in progress is lost; without start nothing is captured.
        scan_bit(1'b1, 1'b1);
        chk("arst_nocap", {12'd0, bit_cnt}, 32'h0);

        // Capture and done_rise in the same cycle.
        ScanNum = 20'd1;
        golden  = 13'h001B;
        pulse_start();
        @(negedge clk);
        digi_out = 1'b1;
        test_se  = 1'b1;
        repeat (3) @(negedge clk);
        TCK       = 1'b1;
        scan_done = 1'b1;
        wait_valid(lat);
        chk("simul_lat", lat, 32'd4);
        chk("simul_cnt", {12'd0, bit_cnt}, 32'd1);
        chk("simul_sig", {19'd0, sig}, 32'h001B);
        chk("simul_pass", {31'd0, pass}, 32'h1);
        finish_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bisg_sig_checker.md
# bisg_sig_checker

Response-side companion to the BISG scan source. It watches the serial scan stream (`TCK`, `test_se`, `digi_out`, `scan_done`) and compacts every scanned bit into a `sigLength`-bit serial-input signature register. It counts the bits and, at end of scan, compares signature and bit count against golden values to produce `pass`. It runs on the system clock `clk`, treats all scan-side signals as asynchronous, and returns `pass` to the BISG top.

## Interface
Parameters:
- `sigLength`, 13, signature width.
- `POLY`, 13'h001B, Galois feedback taps for x^13+x^4+x^3+x+1; bit i set means tap at bit i.
- `SEED`, 0, signature value loaded on `start`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that arms a new check.
- `TCK`  in  1  scan clock, sampled as data.
- `test_se`  in  1  scan enable.
- `digi_out`  in  1  scan data bit.
- `scan_done`  in  1  end-of-scan level from the source.
- `ScanNum`  in  20  expected number of shifted bits.
- `golden`  in  sigLength  expected signature.
- `sig`  out  sigLength  current signature.
- `bit_cnt`  out  20  number of bits captured.
- `pass`  out  1  result; valid only while `pass_valid` is 1.
- `pass_valid`  out  1  a result is available.
- `cnt_err`  out  1  `bit_cnt` differed from `ScanNum` at check.
- `ovf`  out  1  `bit_cnt` saturated.

## Operation
- **Synchronizers.** `TCK`, `test_se`, `digi_out` and `scan_done` each pass through a 2-flop synchronizer.
- **Edge detection.**
  - `tck_rise` = sync2 & ~sync3 on `TCK`.
  - `done_rise` is the same construction on `scan_done`.
- **Capture.** A capture happens when `tck_rise` & `test_se_s` & state==SHIFT. The sampled bit is the synchronized `digi_out` in that same cycle.
- **Compaction** (one step per capture):
  - fb = sig[sigLength-1] ^ din.
  - sig <= {sig[sigLength-2:0],1'b0} ^ (fb ? POLY : 0).
- **Counting.** `bit_cnt` increments by 1 on every capture. At 20'hFFFFF it saturates and sets `ovf`; `ovf` stays set until `start`.
- **FSM states:** IDLE, SHIFT, CHECK, DONE.
  - IDLE -> SHIFT on `start`.
  - SHIFT -> CHECK on `done_rise`.
  - CHECK -> DONE unconditionally, after 1 cycle.
  - DONE -> SHIFT on `start`.
  - `start` in any state, including SHIFT or CHECK, goes to SHIFT.
- **Actions on `start`:**
  - sig <= SEED; bit_cnt <= 0.
  - pass, pass_valid, cnt_err, ovf <= 0.
  - `start` has priority over a capture or `done_rise` in the same cycle.
- **CHECK, on exit to DONE:**
  - cnt_err <= (bit_cnt != ScanNum) | ovf.
  - pass <= (sig == golden) & (bit_cnt == ScanNum) & ~ovf.
  - pass_valid <= 1.
- **DONE** holds `sig`, `bit_cnt`, `pass`, `pass_valid` and `cnt_err` stable. No captures occur outside SHIFT.
- **Simultaneous events.**
  - A capture and `done_rise` in the same SHIFT cycle: the bit is included, then the FSM enters CHECK.
  - CHECK compares the updated `sig`.
- **Mid-scan `test_se` deassertion.** TCK edges seen while `test_se_s`=0 are ignored; the FSM stays in SHIFT.

## Timing
- **Reset values:** state=IDLE; sig=SEED; bit_cnt=0; pass=0; pass_valid=0; cnt_err=0; ovf=0; all synchronizer flops 0.
- **Asynchronous reset.** Reset clears everything immediately, including mid-scan. A scan in progress is lost; a new `start` is required.
- **Capture latency.**
  - A TCK rising edge produces `tck_rise` 2–3 clk later.
  - `sig` and `bit_cnt` update on the clk edge after `tck_rise`.
- **Result latency.** `pass_valid` rises 2 clk after `done_rise` is first seen (1 cycle into CHECK, 1 to DONE).
- **Source constraint.**
  - TCK high and low phases must each be at least 2 clk periods; faster TCK loses bits, which shows up as `cnt_err`.
  - `digi_out` and `test_se` must be stable across the TCK rising edge for at least 3 clk.

## Test plan
- **Single one.** `start`, then 1 bit '1' (`ScanNum`=1, `golden`=13'h001B), then `scan_done` -> `sig`=0x001B, `bit_cnt`=1, `pass`=1 and `pass_valid`=1 2 clk after `done_rise`.
- **One then zero.** Bits '1','0', `ScanNum`=2, `golden`=0x0036 -> `pass`=1. Same stimulus with `golden`=0x0035 -> `pass`=0, `cnt_err`=0.
- **Count mismatch.** 3 zero bits with `ScanNum`=4, `golden`=0 -> `sig`=0, `cnt_err`=1, `pass`=0.
- **Ignored edges.** 5 TCK pulses with `test_se`=0, then 1 bit '1' with `test_se`=1 -> `bit_cnt`=1, `sig`=0x001B.
- **Restart mid-scan.** Scan 3 bits, pulse `start`, then scan '1' and `scan_done` with `ScanNum`=1, `golden`=0x001B -> `pass`=1. Separately, assert `rst_n`=0 mid-scan -> all outputs at reset values within the same cycle.
- **Simultaneous capture and done.** Final bit '1' with `tck_rise` in the same cycle as `done_rise`, `ScanNum`=1 -> `bit_cnt`=1, `sig`=0x001B, `pass`=1.
